// File: rtl/page_scan_ctrl.sv
// Page-select controller for the 4-digit page mux: debounced/auto page toggle,
// digit scanning onto a shared 7-seg bus, and blanking around every page change.
// Ports: clk, rst_n (sync, active-low), btn (raw), auto_en, d0..d3 (mux nibbles,
//        d0 rightmost) -> switch (1=f page), an (active-low anodes), nibble, blank.
module page_scan_ctrl #(
  parameter int DEB_CYCLES  = 250000,
  parameter int SCAN_DIV    = 50000,
  parameter int AUTO_CYCLES = 150000000,
  parameter int BLANK_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       auto_en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic       switch,
  output logic [3:0] an,
  output logic [3:0] nibble,
  output logic       blank
);

  localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int PW = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
  localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_CYCLES - 1);
  localparam logic [BW-1:0] BLK_MAX  = BW'(BLANK_TICKS - 1);

  localparam logic [0:0] S_SHOW  = 1'b0;
  localparam logic [0:0] S_BLANK = 1'b1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb_lvl;
  logic [DW-1:0] r_deb_cnt;
  logic [PW-1:0] r_pre_cnt;
  logic [1:0]    r_idx;
  logic [0:0]    r_state;
  logic          r_switch;
  logic [AW-1:0] r_auto_cnt;
  logic [BW-1:0] r_blk_cnt;
  logic [3:0]    r_an;
  logic [3:0]    r_nibble;

  logic          w_tick;
  logic          w_deb_done;
  logic          w_press;
  logic          w_timeout;
  logic          w_show;
  logic [3:0]    w_dsel;

  assign w_tick     = (r_pre_cnt == PRE_MAX);
  assign w_deb_done = (r_sync2 != r_deb_lvl) && (r_deb_cnt == DEB_MAX);
  // The press pulse coincides with the edge that raises the debounced level.
  assign w_press    = w_deb_done && r_sync2;
  assign w_timeout  = auto_en && (r_auto_cnt == AUTO_MAX);
  assign w_show     = (r_state == S_SHOW);

  always_comb begin
    w_dsel = d0;
    case (r_idx)
      2'd0: w_dsel = d0;
      2'd1: w_dsel = d1;
      2'd2: w_dsel = d2;
      2'd3: w_dsel = d3;
      default: w_dsel = d0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_deb_lvl <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_deb_lvl) begin
      r_deb_cnt <= '0;
    end else if (w_deb_done) begin
      r_deb_lvl <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
      r_idx     <= 2'd0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  // Outputs lag idx/d by one clock; BLANK forces all anodes off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an     <= 4'b1111;
      r_nibble <= 4'h0;
    end else if (w_show) begin
      r_an     <= ~(4'b0001 << r_idx);
      r_nibble <= w_dsel;
    end else begin
      r_an     <= 4'b1111;
      r_nibble <= 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_SHOW;
      r_switch   <= 1'b0;
      r_auto_cnt <= '0;
      r_blk_cnt  <= '0;
    end else begin
      case (r_state)
        S_SHOW: begin
          if (w_press || w_timeout) begin
            r_switch   <= ~r_switch;
            r_auto_cnt <= '0;
            r_blk_cnt  <= '0;
            r_state    <= S_BLANK;
          end else if (auto_en) begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
          end else begin
            r_auto_cnt <= '0;
          end
        end
        S_BLANK: begin
          r_auto_cnt <= '0;
          if (w_tick) begin
            if (r_blk_cnt == BLK_MAX) begin
              r_blk_cnt <= '0;
              r_state   <= S_SHOW;
            end else begin
              r_blk_cnt <= r_blk_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_SHOW;
      endcase
    end
  end

  assign switch = r_switch;
  assign an     = r_an;
  assign nibble = r_nibble;
  assign blank  = (r_state == S_BLANK);

endmodule

// File: tb/tb_page_scan_ctrl.sv
// Self-checking bench for page_scan_ctrl: directed scenarios plus randomized
// button/auto/data stimulus against a cycle-level behavioural model.
module tb_page_scan_ctrl;

  localparam int DEB  = 8;
  localparam int SD   = 4;
  localparam int AUTO = 100;
  localparam int BT   = 2;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       auto_en;
  logic [3:0] d [4];
  logic       switch;
  logic [3:0] an;
  logic [3:0] nibble;
  logic       blank;

  int n_checks;
  int n_fail;

  page_scan_ctrl #(
    .DEB_CYCLES (DEB),
    .SCAN_DIV   (SD),
    .AUTO_CYCLES(AUTO),
    .BLANK_TICKS(BT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .auto_en(auto_en),
    .d0     (d[0]),
    .d1     (d[1]),
    .d2     (d[2]),
    .d3     (d[3]),
    .switch (switch),
    .an     (an),
    .nibble (nibble),
    .blank  (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: time since reset drives the scan position directly,
  // the button is modelled as a delay line plus a stable-run length.
  int         m_cyc;
  int         m_run;
  int         m_auto;
  int         m_blk;
  int         m_toggles;
  logic       m_s1, m_s2, m_lvl;
  logic       m_show, m_sw, m_press, m_tout, m_tick;
  logic [1:0] m_i;
  logic [3:0] m_an, m_nib;
  logic       m_blank;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cyc  = 0; m_run = 0; m_auto = 0; m_blk = 0;
      m_s1   = 0; m_s2  = 0; m_lvl  = 0;
      m_show = 1; m_sw  = 0;
      m_an   = 4'hF; m_nib = 4'h0;
    end else begin
      m_i    = 2'((m_cyc / SD) % 4);
      m_tick = ((m_cyc % SD) == SD - 1);
      m_an   = m_show ? ~(4'b0001 << m_i) : 4'hF;
      m_nib  = m_show ? d[m_i] : 4'h0;
      m_press = 0;
      if (m_s2 != m_lvl) begin
        if (m_run == DEB - 1) begin
          m_press = m_s2;
          m_lvl   = m_s2;
          m_run   = 0;
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
      m_tout = auto_en && (m_auto == AUTO - 1);
      if (m_show) begin
        if (m_press || m_tout) begin
          m_sw = !m_sw; m_show = 0; m_blk = 0; m_auto = 0;
          m_toggles++;
        end else begin
          m_auto = auto_en ? m_auto + 1 : 0;
        end
      end else begin
        m_auto = 0;
        if (m_tick) begin
          if (m_blk == BT - 1) m_show = 1;
          m_blk++;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
      m_cyc++;
    end
    m_blank = !m_show;
  end

  task automatic test_reset();
    logic [3:0] tbl [4];
    logic [3:0] ea, en;
    tbl[0] = 4'b1110; tbl[1] = 4'b1101;
    tbl[2] = 4'b1011; tbl[3] = 4'b0111;
    rst_n = 0; btn = 0; auto_en = 0;
    d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3; d[3] = 4'd4;
    repeat (3) @(negedge clk);
    n_checks++;
    if (switch !== 1'b0) begin n_fail++; $display("FAIL reset_switch: got %b want 0", switch); end
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_checks++;
    if (nibble !== 4'h0) begin n_fail++; $display("FAIL reset_nibble: got %h want 0", nibble); end
    n_checks++;
    if (blank !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b want 0", blank); end
    rst_n = 1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      ea = tbl[((k - 1) / SD) % 4];
      en = 4'(((k - 1) / SD) % 4 + 1);
      n_checks++;
      if (an !== ea || nibble !== en) begin
        n_fail++;
        $display("FAIL scan_seq k=%0d: got an=%b nib=%h want an=%b nib=%h", k, an, nibble, ea, en);
      end
    end
  endtask

  task automatic test_glitch_press();
    int nblank;
    btn = 1;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) btn = 0;
      @(negedge clk);
      n_checks++;
      if ({switch, an, nibble, blank} !== {m_sw, m_an, m_nib, m_blank}) begin
        n_fail++;
        $display("FAIL glitch_model: got %b want %b", {switch, an, nibble, blank}, {m_sw, m_an, m_nib, m_blank});
      end
    end
    n_checks++;
    if (switch !== 1'b0) begin n_fail++; $display("FAIL glitch_no_toggle: got %b want 0", switch); end
    btn = 1;
    nblank = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) btn = 0;
      @(negedge clk);
      if (blank === 1'b1) nblank++;
      n_checks++;
      if ({switch, an, nibble, blank} !== {m_sw, m_an, m_nib, m_blank}) begin
        n_fail++;
        $display("FAIL press_model: got %b want %b", {switch, an, nibble, blank}, {m_sw, m_an, m_nib, m_blank});
      end
    end
    n_checks++;
    if (switch !== 1'b1) begin n_fail++; $display("FAIL press_toggle: got %b want 1", switch); end
    n_checks++;
    if (nblank < (BT - 1) * SD + 1 || nblank > BT * SD) begin
      n_fail++;
      $display("FAIL blank_len: got %0d want %0d..%0d", nblank, (BT - 1) * SD + 1, BT * SD);
    end
  endtask

  task automatic test_auto();
    int   nt;
    logic prev, sw0, early;
    auto_en = 1;
    nt = 0;
    prev = switch;
    for (int i = 0; i < 350; i++) begin
      @(negedge clk);
      if (switch !== prev) nt++;
      prev = switch;
      n_checks++;
      if ({switch, an, nibble, blank} !== {m_sw, m_an, m_nib, m_blank}) begin
        n_fail++;
        $display("FAIL auto_model: got %b want %b", {switch, an, nibble, blank}, {m_sw, m_an, m_nib, m_blank});
      end
    end
    n_checks++;
    if (nt != 3) begin n_fail++; $display("FAIL auto_count: got %0d toggles want 3", nt); end
    auto_en = 0;
    repeat (20) @(negedge clk);
    auto_en = 1;
    repeat (50) @(negedge clk);
    auto_en = 0;
    repeat (3) @(negedge clk);
    auto_en = 1;
    sw0 = switch;
    early = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i < 100 && switch !== sw0) early = 1;
      n_checks++;
      if ({switch, an, nibble, blank} !== {m_sw, m_an, m_nib, m_blank}) begin
        n_fail++;
        $display("FAIL restart_model: got %b want %b", {switch, an, nibble, blank}, {m_sw, m_an, m_nib, m_blank});
      end
    end
    n_checks++;
    if (early) begin n_fail++; $display("FAIL restart_early: got early toggle want none before 100"); end
    n_checks++;
    if (switch === sw0) begin n_fail++; $display("FAIL restart_toggle: got %b want %b", switch, ~sw0); end
    auto_en = 0;
    repeat (20) @(negedge clk);
  endtask

  // btn_at: edge index before which btn rises; press lands 9 edges later.
  task automatic press_vs_timeout(input int btn_at, input string nm);
    logic sw0;
    sw0 = switch;
    auto_en = 1;
    for (int e = 1; e <= 160; e++) begin
      if (e == btn_at) btn = 1;
      if (e == btn_at + 20) btn = 0;
      if (e == 101) auto_en = 0;
      @(negedge clk);
      n_checks++;
      if ({switch, an, nibble, blank} !== {m_sw, m_an, m_nib, m_blank}) begin
        n_fail++;
        $display("FAIL %s_model: got %b want %b", nm, {switch, an, nibble, blank}, {m_sw, m_an, m_nib, m_blank});
      end
    end
    n_checks++;
    if (switch !== ~sw0) begin n_fail++; $display("FAIL %s_single: got %b want %b", nm, switch, ~sw0); end
  endtask

  task automatic test_coincide();
    press_vs_timeout(91, "coincide");
  endtask

  task automatic test_blank_press();
    press_vs_timeout(94, "blank_press");
  endtask

  task automatic test_mid_reset();
    logic found;
    d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3; d[3] = 4'd4;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    btn = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (blank === 1'b1) found = 1;
    end
    n_checks++;
    if (!found || switch !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got blank_seen=%b sw=%b want 1 1", found, switch);
    end
    rst_n = 0;
    btn = 0;
    @(negedge clk);
    n_checks++;
    if ({switch, blank, an, nibble} !== {1'b0, 1'b0, 4'b1111, 4'h0}) begin
      n_fail++;
      $display("FAIL mid_reset_vals: got sw=%b blank=%b an=%b nib=%h want 0 0 1111 0", switch, blank, an, nibble);
    end
    rst_n = 1;
    for (int k = 0; k < SD; k++) begin
      @(negedge clk);
      n_checks++;
      if (an !== 4'b1110 || nibble !== 4'd1) begin
        n_fail++;
        $display("FAIL mid_reset_idx0: got an=%b nib=%h want 1110 1", an, nibble);
      end
    end
  endtask

  task automatic test_mid_slot_d();
    logic [3:0] an0, en;
    logic [1:0] ix;
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < SD && (m_cyc % SD) != 1; w++) @(negedge clk);
      an0 = an;
      for (int j = 0; j < 4; j++) d[j] = 4'($urandom);
      @(negedge clk);
      ix = 2'(((m_cyc - 1) / SD) % 4);
      en = d[ix];
      n_checks++;
      if (an !== an0 || nibble !== en) begin
        n_fail++;
        $display("FAIL mid_slot_d: got an=%b nib=%h want an=%b nib=%h", an, nibble, an0, en);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_random();
    int hold;
    int t0;
    hold = 0;
    t0 = m_toggles;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      if (hold == 0) begin
        btn  = ~btn;
        hold = $urandom_range(1, 25);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 3)] = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if ({switch, an, nibble, blank} !== {m_sw, m_an, m_nib, m_blank}) begin
        n_fail++;
        $display("FAIL random_model i=%0d: got %b want %b", i, {switch, an, nibble, blank}, {m_sw, m_an, m_nib, m_blank});
      end
    end
    rst_n = 1;
    n_checks++;
    if (m_toggles - t0 < 10) begin
      n_fail++;
      $display("FAIL random_activity: got %0d toggles want >=10", m_toggles - t0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    m_toggles = 0;
    rst_n = 0;
    btn = 0;
    auto_en = 0;
    for (int j = 0; j < 4; j++) d[j] = 4'h0;
    test_reset();
    test_glitch_press();
    test_auto();
    test_coincide();
    test_blank_press();
    test_mid_reset();
    test_mid_slot_d();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
